// File: rtl/conf_regs.sv
// Memory-mapped config/peripheral register file on the conf_* bus: scratch, LED, switch, seven-seg, timer.
// Optional timer compare interrupt is built when CONF_TIMER_IRQ_EN is defined.
module conf_regs #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter int unsigned LED_WIDTH = 16,
  parameter int unsigned SW_WIDTH  = 8
) (
`ifdef CONF_TIMER_IRQ_EN
  output logic                 timer_irq,
`endif
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 conf_en,
  input  logic [3:0]           conf_wen,
  input  logic [31:0]          conf_addr,
  input  logic [31:0]          conf_wdata,
  output logic [31:0]          conf_rdata,
  output logic [LED_WIDTH-1:0] led,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [7:0]           seg_an,
  output logic [6:0]           seg_code
);

  localparam logic [15:0] ADDR_SCRATCH   = 16'h8000;
  localparam logic [15:0] ADDR_TIMER     = 16'hE000;
`ifdef CONF_TIMER_IRQ_EN
  localparam logic [15:0] ADDR_TIMER_CMP = 16'hE004;
`endif
  localparam logic [15:0] ADDR_LED       = 16'hF000;
  localparam logic [15:0] ADDR_SWITCH    = 16'hF00C;
  localparam logic [15:0] ADDR_NUM       = 16'hF010;

  logic [15:0]         addr;
  logic                wr;
  logic                unused_addr_hi;
  logic [31:0]         scratch;
  logic [31:0]         timer;
  logic [31:0]         num;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [31:0]         rd_val;
  logic [15:0]         scan_cnt;
  logic [2:0]          digit;
  logic [2:0]          digit_nx;

  assign addr           = conf_addr[15:0];
  assign unused_addr_hi = ^conf_addr[31:16];
  assign wr             = conf_en && (|conf_wen);
  assign digit_nx       = digit + 3'd1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

`ifdef CONF_TIMER_IRQ_EN
  logic [31:0] timer_cmp;

  // A compare-register write clears the flag even if a match lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_cmp <= '0;
      timer_irq <= 1'b0;
    end else if (wr && addr == ADDR_TIMER_CMP) begin
      timer_cmp <= merge(timer_cmp, conf_wdata, conf_wen);
      timer_irq <= 1'b0;
    end else if (timer_cmp != '0 && timer == timer_cmp) begin
      timer_irq <= 1'b1;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_SCRATCH:   rd_val = scratch;
      ADDR_TIMER:     rd_val = timer;
`ifdef CONF_TIMER_IRQ_EN
      ADDR_TIMER_CMP: rd_val = timer_cmp;
`endif
      ADDR_LED:       rd_val = 32'(led);
      ADDR_SWITCH:    rd_val = 32'(sw_sync);
      ADDR_NUM:       rd_val = num;
      default:        rd_val = '0;
    endcase
  end

  // Read data is captured before the same-edge write lands, giving read-old semantics.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch    <= '0;
      timer      <= '0;
      num        <= '0;
      led        <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      conf_rdata <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (conf_en)
        conf_rdata <= rd_val;
      timer <= timer + 32'd1;
      if (wr) begin
        case (addr)
          ADDR_SCRATCH: scratch <= merge(scratch, conf_wdata, conf_wen);
          ADDR_TIMER:   timer   <= merge(timer, conf_wdata, conf_wen);
          ADDR_LED:     led     <= LED_WIDTH'(merge(32'(led), conf_wdata, conf_wen));
          ADDR_NUM:     num     <= merge(num, conf_wdata, conf_wen);
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
      seg_an   <= 8'hFE;
      seg_code <= glyph(4'h0);
    end else if (scan_cnt == SCAN_DIV - 16'd1) begin
      scan_cnt <= '0;
      digit    <= digit_nx;
      seg_an   <= ~(8'b1 << digit_nx);
      seg_code <= glyph(num[{digit_nx, 2'b00} +: 4]);
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

endmodule
